// File: rtl/imm_encoder_pkg.sv
// ---------------------------------------------------------------------------
// imm_encoder_pkg
// Shared definitions for the immediate encoder: instruction type codes (the
// same encoding the decode stage uses), immediate range limits, field bit
// positions, and a helper that range-checks a signed immediate.
// ---------------------------------------------------------------------------
package imm_encoder_pkg;

  // Instruction format codes; anything not listed is treated as an error.
  typedef enum logic [2:0] {
    INST_R = 3'd0,
    INST_I = 3'd1,
    INST_S = 3'd2,
    INST_B = 3'd3,
    INST_U = 3'd4,
    INST_J = 3'd5
  } inst_type_e;

  // Highest immediate bit that must still be a copy of the sign for a value
  // to fit the 12-bit (I/S/B) or 20-bit (U/J) fields.
  localparam int unsigned IMM12_SIGN_BIT = 11;
  localparam int unsigned IMM20_SIGN_BIT = 19;

  // Shift-amount width for the I-type shift form.
  localparam int unsigned SHAMT_W = 5;

  // Field bit positions inside the instruction word.
  localparam int unsigned I_IMM_LSB     = 20;
  localparam int unsigned SHAMT_LSB     = 20;
  localparam int unsigned S_HI_LSB      = 25;
  localparam int unsigned S_LO_LSB      = 7;
  localparam int unsigned B_MID_LSB     = 25;
  localparam int unsigned B_LO_LSB      = 8;
  localparam int unsigned B_BIT10_POS   = 7;
  localparam int unsigned U_IMM_LSB     = 12;
  localparam int unsigned J_MID_LSB     = 12;
  localparam int unsigned J_BIT10_POS   = 20;
  localparam int unsigned J_LO_LSB      = 21;

  // True when imm[31:signBit] are all equal, i.e. the value fits a signed
  // field whose top bit is signBit.
  function automatic logic fitsSigned(input logic [31:0] imm,
                                      input int unsigned signBit);
    logic [31:0] upper;
    upper = 32'($signed(imm) >>> signBit);
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// ---------------------------------------------------------------------------
// imm_field_pack
// Purely combinational immediate packer. Places the immediate into the
// type-specific fields of the base instruction and flags values that do not
// fit. On error the base word is passed through untouched.
//   instType_i : instruction format code
//   shift_i    : I-type shift-immediate form (5-bit unsigned shamt)
//   imm_i      : signed immediate as decode would produce it
//   base_i     : instruction whose non-immediate bits are kept
//   packed_o   : base with immediate fields replaced (or base on error)
//   err_o      : range or type error
// ---------------------------------------------------------------------------
module imm_field_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  instType_i,
  input  logic        shift_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] base_i,
  output logic [31:0] packed_o,
  output logic        err_o
);

  // Field placement per format; the error decision is made alongside and the
  // base word is restored at the end so no partial patch can leak out.
  always_comb begin
    packed_o = base_i;
    err_o    = 1'b0;
    case (inst_type_e'(instType_i))
      INST_I: begin
        if (shift_i) begin
          // Upper funct7 bits stay from the base so SRAI/SRLI keep their opcode.
          err_o = |imm_i[31:SHAMT_W];
          packed_o[SHAMT_LSB +: SHAMT_W] = imm_i[SHAMT_W-1:0];
        end else begin
          err_o = !fitsSigned(imm_i, IMM12_SIGN_BIT);
          packed_o[I_IMM_LSB +: 12] = imm_i[11:0];
        end
      end
      INST_S: begin
        err_o = !fitsSigned(imm_i, IMM12_SIGN_BIT);
        packed_o[S_HI_LSB +: 7] = imm_i[11:5];
        packed_o[S_LO_LSB +: 5] = imm_i[4:0];
      end
      INST_B: begin
        err_o = !fitsSigned(imm_i, IMM12_SIGN_BIT);
        packed_o[31]             = imm_i[11];
        packed_o[B_BIT10_POS]    = imm_i[10];
        packed_o[B_MID_LSB +: 6] = imm_i[9:4];
        packed_o[B_LO_LSB +: 4]  = imm_i[3:0];
      end
      INST_U: begin
        err_o = !fitsSigned(imm_i, IMM20_SIGN_BIT);
        packed_o[U_IMM_LSB +: 20] = imm_i[19:0];
      end
      INST_J: begin
        err_o = !fitsSigned(imm_i, IMM20_SIGN_BIT);
        packed_o[31]              = imm_i[19];
        packed_o[J_MID_LSB +: 8]  = imm_i[18:11];
        packed_o[J_BIT10_POS]     = imm_i[10];
        packed_o[J_LO_LSB +: 10]  = imm_i[9:0];
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
    if (err_o) begin
      packed_o = base_i;
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
// Two-stage valid/ready pipeline that patches an immediate into a base
// instruction. S1 captures the packed word, base and error flag; S2 holds the
// final word presented to the consumer. Full backpressure, 1 result/cycle.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid/ready: request handshake
//   in_inst_type  : instruction format code
//   in_shift      : I-type shift-immediate form
//   in_base       : instruction whose non-immediate bits are kept
//   in_imm        : signed immediate
//   out_valid/ready: result handshake
//   out_inst      : patched instruction (base on error)
//   out_err       : range or type error
//   err_cnt       : saturating count of delivered error results
// ---------------------------------------------------------------------------
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_inst_type,
  input  logic                 in_shift,
  input  logic [31:0]          in_base,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                 s1Valid_q, s1Valid_d;
  logic [31:0]          s1Packed_q, s1Packed_d;
  logic [31:0]          s1Base_q, s1Base_d;
  logic                 s1Err_q, s1Err_d;
  logic                 s2Valid_q, s2Valid_d;
  logic [31:0]          s2Inst_q, s2Inst_d;
  logic                 s2Err_q, s2Err_d;
  logic [ERR_CNT_W-1:0] errCnt_q, errCnt_d;

  logic [31:0] packedWord;
  logic        packErr;
  logic        s2Ready;

  imm_field_pack u_pack (
    .instType_i (in_inst_type),
    .shift_i    (in_shift),
    .imm_i      (in_imm),
    .base_i     (in_base),
    .packed_o   (packedWord),
    .err_o      (packErr)
  );

  // A stage can take new data when it is empty or its content leaves this
  // cycle, which lets S1 refill while S2 drains with no bubble.
  assign s2Ready  = !s2Valid_q || out_ready;
  assign in_ready = !s1Valid_q || s2Ready;

  // Next-state for both stages and the error counter. Data registers only
  // load on a real transfer so stalled contents stay put.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Packed_d = s1Packed_q;
    s1Base_d   = s1Base_q;
    s1Err_d    = s1Err_q;
    s2Valid_d  = s2Valid_q;
    s2Inst_d   = s2Inst_q;
    s2Err_d    = s2Err_q;
    errCnt_d   = errCnt_q;

    if (in_ready) begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        s1Packed_d = packedWord;
        s1Base_d   = in_base;
        s1Err_d    = packErr;
      end
    end

    if (s2Ready) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Inst_d = s1Err_q ? s1Base_q : s1Packed_q;
        s2Err_d  = s1Err_q;
      end
    end

    if (s2Valid_q && out_ready && s2Err_q && (errCnt_q != '1)) begin
      errCnt_d = errCnt_q + 1'b1;
    end
  end

  // State registers; reset drops anything in flight and clears the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Packed_q <= '0;
      s1Base_q   <= '0;
      s1Err_q    <= 1'b0;
      s2Valid_q  <= 1'b0;
      s2Inst_q   <= '0;
      s2Err_q    <= 1'b0;
      errCnt_q   <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Packed_q <= s1Packed_d;
      s1Base_q   <= s1Base_d;
      s1Err_q    <= s1Err_d;
      s2Valid_q  <= s2Valid_d;
      s2Inst_q   <= s2Inst_d;
      s2Err_q    <= s2Err_d;
      errCnt_q   <= errCnt_d;
    end
  end

  assign out_valid = s2Valid_q;
  assign out_inst  = s2Inst_q;
  assign out_err   = s2Err_q;
  assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_encoder
// Self-checking bench for imm_encoder built with a 4-bit error counter.
// Requests are driven one step after the rising edge; outputs are sampled on
// the falling edge. Expected results are queued on accept and compared when
// the encoder delivers them.
// ---------------------------------------------------------------------------
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_inst_type;
  logic             in_shift;
  logic [31:0]      in_base;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [2:0]  t;
    logic        sh;
    logic [31:0] imm;
    int          acceptCycle;
    bit          checkLat;
  } expItem_t;

  expItem_t   expQ[$];
  int         testsRun = 0;
  int         testsFailed = 0;
  int         cycleCnt = 0;
  int         occ = 0;
  bit         latencyNext = 0;
  bit         patternMode = 0;
  int         patIdx = 0;
  logic [CNT_W-1:0] modelCnt = '0;
  bit         stalledPrev = 0;
  logic [31:0] heldInst;
  logic        heldErr;

  imm_encoder #(.ERR_CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst_type (in_inst_type),
    .in_shift     (in_shift),
    .in_base      (in_base),
    .in_imm       (in_imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_err      (out_err),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder written from the field tables using signed ranges.
  function automatic void modelEncode(input logic [2:0] t, input logic sh,
                                      input logic [31:0] base, input logic [31:0] imm,
                                      output logic [31:0] inst, output logic err);
    int v;
    v    = int'($signed(imm));
    inst = base;
    err  = 1'b0;
    case (t)
      3'd1: begin
        if (sh) begin
          if (imm > 32'd31) err = 1'b1;
          else inst[24:20] = imm[4:0];
        end else begin
          if (v < -2048 || v > 2047) err = 1'b1;
          else inst[31:20] = imm[11:0];
        end
      end
      3'd2: begin
        if (v < -2048 || v > 2047) err = 1'b1;
        else begin inst[31:25] = imm[11:5]; inst[11:7] = imm[4:0]; end
      end
      3'd3: begin
        if (v < -2048 || v > 2047) err = 1'b1;
        else begin
          inst[31] = imm[11]; inst[7] = imm[10];
          inst[30:25] = imm[9:4]; inst[11:8] = imm[3:0];
        end
      end
      3'd4: begin
        if (v < -524288 || v > 524287) err = 1'b1;
        else inst[31:12] = imm[19:0];
      end
      3'd5: begin
        if (v < -524288 || v > 524287) err = 1'b1;
        else begin
          inst[31] = imm[19]; inst[19:12] = imm[18:11];
          inst[20] = imm[10]; inst[30:21] = imm[9:0];
        end
      end
      default: err = 1'b1;
    endcase
    if (err) inst = base;
  endfunction

  // Decode-stage immediate extraction, used for the round-trip check.
  function automatic logic [31:0] decodeImm(input logic [2:0] t, input logic sh,
                                            input logic [31:0] inst);
    case (t)
      3'd1: return sh ? {27'b0, inst[24:20]} : {{20{inst[31]}}, inst[31:20]};
      3'd2: return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      3'd3: return {{20{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8]};
      3'd4: return {{12{inst[31]}}, inst[31:12]};
      3'd5: return {{12{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21]};
      default: return 32'h0;
    endcase
  endfunction

  // Drive one request with given expectations; pushes the expectation on the
  // falling edge before the accepting rising edge. Entered/left at posedge+1.
  task automatic applyDirected(input logic [2:0] t, input logic sh,
                               input logic [31:0] base, input logic [31:0] imm,
                               input logic [31:0] expInst, input logic expErr);
    expItem_t item;
    bit done;
    in_valid     = 1'b1;
    in_inst_type = t;
    in_shift     = sh;
    in_base      = base;
    in_imm       = imm;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        item.inst = expInst; item.err = expErr; item.t = t; item.sh = sh;
        item.imm = imm; item.acceptCycle = cycleCnt; item.checkLat = latencyNext;
        expQ.push_back(item);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("acceptTimeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] t, input logic sh,
                               input logic [31:0] base, input logic [31:0] imm);
    logic [31:0] ei;
    logic ee;
    modelEncode(t, sh, base, imm, ei, ee);
    applyDirected(t, sh, base, imm, ei, ee);
  endtask

  // Wait for every queued result to be delivered (bounded).
  task automatic waitDrain();
    for (int n = 0; n < 200 && expQ.size() != 0; n++) @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("drain", expQ.size(), 32'd0);
  endtask

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Items currently held inside the encoder, tracked from the handshakes.
  always @(posedge clk) begin
    if (rst) occ <= 0;
    else occ <= occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
  end

  // Consumer-side backpressure pattern 1,0,0,1,0,0...
  always @(posedge clk) begin
    #1;
    if (patternMode) begin
      out_ready = (patIdx % 3 == 0);
      patIdx++;
    end
  end

  // Output monitor: ready rule, counter, stall stability and scoreboard.
  always @(negedge clk) begin
    expItem_t item;
    if (rst) begin
      modelCnt    = '0;
      stalledPrev = 0;
    end else begin
      checkOutput("inReady", {31'b0, in_ready}, {31'b0, !(occ == 2 && !out_ready)});
      checkOutput("errCnt", {28'b0, err_cnt}, {28'b0, modelCnt});
      if (stalledPrev) begin
        checkOutput("stallValid", {31'b0, out_valid}, 32'd1);
        checkOutput("stallInst", out_inst, heldInst);
        checkOutput("stallErr", {31'b0, out_err}, {31'b0, heldErr});
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousOut", {31'b0, out_valid}, 32'd0);
        end else begin
          item = expQ.pop_front();
          checkOutput("outInst", out_inst, item.inst);
          checkOutput("outErr", {31'b0, out_err}, {31'b0, item.err});
          if (!item.err) checkOutput("roundTrip", decodeImm(item.t, item.sh, out_inst), item.imm);
          if (item.checkLat) checkOutput("latency", cycleCnt, item.acceptCycle + 2);
          if (out_err && modelCnt != '1) modelCnt = modelCnt + 1'b1;
        end
      end
      stalledPrev = out_valid && !out_ready;
      heldInst    = out_inst;
      heldErr     = out_err;
    end
  end

  initial begin
    logic [2:0] types12[3];
    logic [2:0] types20[2];
    logic [31:0] b12[4];
    logic [31:0] b20[4];
    types12 = '{3'd1, 3'd2, 3'd3};
    types20 = '{3'd4, 3'd5};
    b12 = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF};
    b20 = '{32'd524287, 32'd524288, 32'hFFF8_0000, 32'hFFF7_FFFF};

    rst = 1'b1; in_valid = 1'b0; in_inst_type = '0; in_shift = 1'b0;
    in_base = '0; in_imm = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstOutInst", out_inst, 32'd0);
    checkOutput("rstOutErr", {31'b0, out_err}, 32'd0);
    checkOutput("rstErrCnt", {28'b0, err_cnt}, 32'd0);
    checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // I-type with latency check
    latencyNext = 1;
    applyDirected(INST_I, 1'b0, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0);
    latencyNext = 0;
    waitDrain();

    // I-shift legal and out of range
    applyDirected(INST_I, 1'b1, 32'h4000_5013, 32'd31, 32'h41F0_5013, 1'b0);
    applyDirected(INST_I, 1'b1, 32'h4000_5013, 32'd32, 32'h4000_5013, 1'b1);
    waitDrain();
    checkOutput("errCntOne", {28'b0, err_cnt}, 32'd1);

    // B-type extremes
    applyDirected(INST_B, 1'b0, 32'h0000_0063, 32'hFFFF_F800, 32'h8000_0063, 1'b0);
    applyDirected(INST_B, 1'b0, 32'h0000_0063, 32'd2048, 32'h0000_0063, 1'b1);
    waitDrain();

    // Random legal sweep and range boundaries for every format
    for (int k = 0; k < 4; k++) begin
      foreach (types12[i])
        applyStimulus(types12[i], 1'b0, $urandom, 32'($urandom_range(0, 4095)) - 32'd2048);
      foreach (types20[i])
        applyStimulus(types20[i], 1'b0, $urandom, 32'($urandom_range(0, 1048575)) - 32'd524288);
    end
    foreach (types12[i]) foreach (b12[j]) applyStimulus(types12[i], 1'b0, $urandom, b12[j]);
    foreach (types20[i]) foreach (b20[j]) applyStimulus(types20[i], 1'b0, $urandom, b20[j]);
    applyStimulus(3'd0, 1'b0, 32'h1234_5678, 32'd5);
    applyStimulus(3'd7, 1'b0, 32'h1234_5678, 32'd5);
    waitDrain();

    // Backpressure stream of 8 back-to-back requests
    patIdx = 0;
    patternMode = 1;
    for (int k = 0; k < 8; k++)
      applyStimulus(INST_S, 1'b0, $urandom, 32'($urandom_range(0, 4095)) - 32'd2048);
    patternMode = 0;
    out_ready = 1'b1;
    waitDrain();

    // Reset with two requests in flight
    out_ready = 1'b0;
    applyStimulus(INST_U, 1'b0, 32'h0000_0037, 32'd100);
    applyStimulus(INST_J, 1'b0, 32'h0000_006F, 32'hFFFF_FFF0);
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("midRstErrCnt", {28'b0, err_cnt}, 32'd0);
    checkOutput("midRstInReady", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Counter saturation: 2^4+3 error results
    for (int k = 0; k < 19; k++) applyStimulus(3'd7, 1'b0, $urandom, $urandom);
    waitDrain();
    checkOutput("errCntSat", {28'b0, err_cnt}, 32'h0000_000F);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
